// File: rtl/lsu_pkg.sv
// Shared LSU definitions: funct3 width/sign codes, FSM states, byte-lane masks.
// Pure declarations and helpers; no storage, no latency.
// No flow control here; consumers handle their own handshakes.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-lane masks for an access that starts at lane 0.
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  // Legal = known width code, naturally aligned, and stores only use signed codes.
  function automatic logic lsu_legal(input logic wen, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~off[0];
      F3_W:        ok = (off == 2'b00);
      default:     ok = 1'b0;
    endcase
    if (wen && f3[2]) ok = 1'b0;
    return ok;
  endfunction

  // Lane-0 mask for the access width encoded in funct3[1:0].
  function automatic logic [3:0] lsu_width_mask(input logic [2:0] f3);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = MASK_B;
      2'b01:   m = MASK_H;
      default: m = MASK_W;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load alignment: shifts the addressed byte lane down and sign/zero extends.
// Purely combinational, zero latency.
// No flow control; result is valid whenever the inputs are.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  // Pick the access width and extend according to the signedness bit.
  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_W:    data_o = shifted;
      F3_BU:   data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// LSU memory master: one load/store from EXU to the synchronous data SRAM, result to WBU.
// Latency accept->out_valid: load 3, store 2, illegal/misaligned 1 cycle.
// Single outstanding request; in_ready drops until the response handshake completes.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic              out_err,
  output logic [XLEN-1:0]   mem_raddr,
  output logic [XLEN-1:0]   mem_waddr,
  output logic [MASK_W-1:0] mem_wmask,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_e      state_q, state_d;
  logic            wen_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            accept;
  logic            req_legal;
  logic [XLEN-1:0] load_data;
  logic [3:0]      wmask4;

  assign accept    = (state_q == ST_IDLE) && in_valid;
  assign req_legal = lsu_legal(in_wen, in_funct3, in_addr[1:0]);

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i  (mem_rdata),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  // State register; reset aborts any in-flight request and drops the strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: illegal requests skip memory and go straight to the response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = req_legal ? ST_REQ : ST_RESP;
      ST_REQ:  state_d = wen_q ? ST_RESP : ST_WAIT;
      ST_WAIT: state_d = ST_RESP;
      ST_RESP: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and the latched request.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_rdata = '0;
    out_err   = 1'b0;
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    wmask4    = 4'b0000;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_REQ: begin
        mem_r_en = ~wen_q;
        mem_w_en = wen_q;
        if (wen_q) wmask4 = lsu_width_mask(f3_q) << addr_q[1:0];
      end
      ST_RESP: begin
        out_valid = 1'b1;
        out_rdata = rdata_q;
        out_err   = err_q;
      end
      default: ;
    endcase
  end

  assign mem_raddr = {addr_q[XLEN-1:2], 2'b00};
  assign mem_waddr = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
  assign mem_wmask = {{(MASK_W-4){1'b0}}, wmask4};

  // Result/error next values: cleared on accept and after the response handshake.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      rdata_d = '0;
      err_d   = ~req_legal;
    end else if (state_q == ST_WAIT) begin
      rdata_d = load_data;
    end else if ((state_q == ST_RESP) && out_ready) begin
      rdata_d = '0;
      err_d   = 1'b0;
    end
  end

  // Request latch on accept, plus the result/error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        wen_q   <= in_wen;
        f3_q    <= in_funct3;
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
      end
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
